// File: rtl/iq_pkg.sv
// Shared parameters, entry-state type and helpers for the issue-queue scheduler.
package iq_pkg;
    localparam int PRF_WIDTH  = 6;
    localparam int IQ_DEPTH   = 16;
    localparam int IQ_IDX_W   = 4;
    localparam int DISPATCH_W = 4;
    localparam int ISSUE_W    = 2;
    localparam int WB_W       = 2;

    typedef struct packed {
        logic                 valid;
        logic                 s1_rdy;
        logic                 s2_rdy;
        logic [PRF_WIDTH-1:0] prs1;
        logic [PRF_WIDTH-1:0] prs2;
        logic [PRF_WIDTH-1:0] prd;
        logic                 prd_v;
    } entry_t;

    function automatic logic [IQ_IDX_W-1:0] onehot_to_idx(input logic [IQ_DEPTH-1:0] oh);
        logic [IQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (oh[i]) idx = idx | IQ_IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/iq_scheduler_age_select.sv
// Oldest-ready picker: one-hot selection of the candidate that no other candidate is older than.
module age_select
    import iq_pkg::*;
(
    input  logic [IQ_DEPTH-1:0]               i_ready,
    input  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] i_older,
    input  logic [IQ_DEPTH-1:0]               i_exclude,
    output logic [IQ_DEPTH-1:0]               o_pick,
    output logic                              o_valid
);
    logic [IQ_DEPTH-1:0]               w_cand;
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] w_col;

    assign w_cand = i_ready & ~i_exclude;

    // w_col[gi][gj] = entry gj is older than entry gi
    for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_pick
        for (genvar gj = 0; gj < IQ_DEPTH; gj++) begin : g_col
            assign w_col[gi][gj] = i_older[gj][gi];
        end
        assign o_pick[gi] = w_cand[gi] & ~|(w_cand & w_col[gi]);
    end

    assign o_valid = |w_cand;
endmodule

// File: rtl/iq_scheduler.sv
// Wakeup/select scheduler for the 16-entry issue queue: age-ordered dual-port select.
// Build option IQ_SPEC_WAKEUP_EN: granted destination tags also wake dependents at the grant edge.
module iq_scheduler
    import iq_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [DISPATCH_W-1:0]           alloc_v,
    input  logic [IQ_IDX_W*DISPATCH_W-1:0]  alloc_addr,
    input  logic [PRF_WIDTH*DISPATCH_W-1:0] alloc_prs1,
    input  logic [PRF_WIDTH*DISPATCH_W-1:0] alloc_prs2,
    input  logic [PRF_WIDTH*DISPATCH_W-1:0] alloc_prd,
    input  logic [DISPATCH_W-1:0]           alloc_prs1_v,
    input  logic [DISPATCH_W-1:0]           alloc_prs2_v,
    input  logic [DISPATCH_W-1:0]           alloc_prd_v,
    input  logic [DISPATCH_W-1:0]           alloc_prs1_rdy,
    input  logic [DISPATCH_W-1:0]           alloc_prs2_rdy,
    input  logic [WB_W-1:0]                 wb_v,
    input  logic [PRF_WIDTH*WB_W-1:0]       wb_tag,
    input  logic [ISSUE_W-1:0]              fu_rdy,
    output logic [ISSUE_W-1:0]              issue_v,
    output logic [IQ_IDX_W*ISSUE_W-1:0]     issue_idx,
    output logic [PRF_WIDTH*ISSUE_W-1:0]    issue_prd,
    output logic [ISSUE_W-1:0]              issue_prd_v,
    output logic [IQ_DEPTH-1:0]             free_mask,
    output logic [4:0]                      iq_count
);
`ifdef IQ_SPEC_WAKEUP_EN
    localparam int NWK = WB_W + ISSUE_W;
`else
    localparam int NWK = WB_W;
`endif

    entry_t                            r_entry [IQ_DEPTH];
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] r_older;
    logic [4:0]                        r_count;

    entry_t                            w_entry_next [IQ_DEPTH];
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] w_older_next;
    logic [4:0]                        w_count_next;
    logic [IQ_DEPTH-1:0]               w_valid, w_ready, w_surv, w_grant_mask, w_alloc_mask;
    logic [IQ_DEPTH-1:0]               w_pick [ISSUE_W];
    logic [IQ_DEPTH-1:0]               w_excl [ISSUE_W];
    logic [IQ_DEPTH-1:0]               w_slot_oh [DISPATCH_W];
    logic [IQ_DEPTH-1:0]               w_lower [DISPATCH_W];
    logic [IQ_IDX_W-1:0]               w_idx [ISSUE_W];
    logic [ISSUE_W-1:0]                w_grant;
    logic [NWK-1:0]                    w_wk_v;
    logic [NWK-1:0][PRF_WIDTH-1:0]     w_wk_tag;
    logic [DISPATCH_W-1:0]             w_eff, w_a1_hit, w_a2_hit;
    logic [IQ_DEPTH-1:0]               w_s1_hit, w_s2_hit;

    for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_state
        assign w_valid[gi] = r_entry[gi].valid;
        assign w_ready[gi] = r_entry[gi].valid & r_entry[gi].s1_rdy & r_entry[gi].s2_rdy;
    end

    assign w_excl[0] = '0;
    assign w_excl[1] = w_pick[0];

    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_port
        age_select u_sel (
            .i_ready   (w_ready),
            .i_older   (r_older),
            .i_exclude (w_excl[gi]),
            .o_pick    (w_pick[gi]),
            .o_valid   (issue_v[gi])
        );
        assign w_idx[gi]                               = onehot_to_idx(w_pick[gi]);
        assign issue_idx[gi*IQ_IDX_W +: IQ_IDX_W]      = w_idx[gi];
        assign issue_prd[gi*PRF_WIDTH +: PRF_WIDTH]    = r_entry[w_idx[gi]].prd;
        assign issue_prd_v[gi]                         = issue_v[gi] & r_entry[w_idx[gi]].prd_v;
        assign w_grant[gi]                             = issue_v[gi] & fu_rdy[gi];
    end

    assign w_grant_mask = (w_pick[0] & {IQ_DEPTH{w_grant[0]}}) | (w_pick[1] & {IQ_DEPTH{w_grant[1]}});
    assign w_surv       = w_valid & ~w_grant_mask;
    assign free_mask    = ~w_valid;
    assign iq_count     = r_count;

    for (genvar gi = 0; gi < WB_W; gi++) begin : g_wb
        assign w_wk_v[gi]   = wb_v[gi];
        assign w_wk_tag[gi] = wb_tag[gi*PRF_WIDTH +: PRF_WIDTH];
    end
`ifdef IQ_SPEC_WAKEUP_EN
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_spec
        assign w_wk_v[WB_W+gi]   = w_grant[gi] & issue_prd_v[gi];
        assign w_wk_tag[WB_W+gi] = issue_prd[gi*PRF_WIDTH +: PRF_WIDTH];
    end
`endif

    // A slot only takes effect if no lower-numbered slot targets the same entry.
    always_comb begin
        w_alloc_mask = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            w_eff[k] = alloc_v[k];
            for (int m = 0; m < k; m++) begin
                if (alloc_v[m] && alloc_addr[m*IQ_IDX_W +: IQ_IDX_W] == alloc_addr[k*IQ_IDX_W +: IQ_IDX_W])
                    w_eff[k] = 1'b0;
            end
            w_lower[k]   = w_alloc_mask;
            w_slot_oh[k] = w_eff[k] ? (IQ_DEPTH'(1) << alloc_addr[k*IQ_IDX_W +: IQ_IDX_W]) : '0;
            w_alloc_mask = w_alloc_mask | w_slot_oh[k];
        end
    end

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_s1_hit[i] = 1'b0;
            w_s2_hit[i] = 1'b0;
            for (int w = 0; w < NWK; w++) begin
                if (w_wk_v[w] && r_entry[i].prs1 == w_wk_tag[w]) w_s1_hit[i] = 1'b1;
                if (w_wk_v[w] && r_entry[i].prs2 == w_wk_tag[w]) w_s2_hit[i] = 1'b1;
            end
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            w_a1_hit[k] = 1'b0;
            w_a2_hit[k] = 1'b0;
            for (int w = 0; w < NWK; w++) begin
                if (w_wk_v[w] && alloc_prs1[k*PRF_WIDTH +: PRF_WIDTH] == w_wk_tag[w]) w_a1_hit[k] = 1'b1;
                if (w_wk_v[w] && alloc_prs2[k*PRF_WIDTH +: PRF_WIDTH] == w_wk_tag[w]) w_a2_hit[k] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_entry_next[i]        = r_entry[i];
            w_entry_next[i].valid  = w_surv[i];
            w_entry_next[i].s1_rdy = r_entry[i].s1_rdy | w_s1_hit[i];
            w_entry_next[i].s2_rdy = r_entry[i].s2_rdy | w_s2_hit[i];
            for (int j = 0; j < IQ_DEPTH; j++) begin
                w_older_next[i][j] = r_older[i][j] & w_surv[i] & w_surv[j] & ~w_alloc_mask[i];
            end
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (w_slot_oh[k][i]) begin
                    w_entry_next[i].valid  = 1'b1;
                    w_entry_next[i].prs1   = alloc_prs1[k*PRF_WIDTH +: PRF_WIDTH];
                    w_entry_next[i].prs2   = alloc_prs2[k*PRF_WIDTH +: PRF_WIDTH];
                    w_entry_next[i].prd    = alloc_prd[k*PRF_WIDTH +: PRF_WIDTH];
                    w_entry_next[i].prd_v  = alloc_prd_v[k];
                    w_entry_next[i].s1_rdy = ~alloc_prs1_v[k] | alloc_prs1_rdy[k] | w_a1_hit[k];
                    w_entry_next[i].s2_rdy = ~alloc_prs2_v[k] | alloc_prs2_rdy[k] | w_a2_hit[k];
                    // Survivors and earlier slots of this cycle are older than the new entry.
                    for (int j = 0; j < IQ_DEPTH; j++) begin
                        w_older_next[j][i] = w_surv[j] | w_lower[k][j];
                    end
                end
            end
        end
        w_count_next = r_count;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_count_next = w_count_next + 5'(w_alloc_mask[i]) - 5'(w_grant_mask[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IQ_DEPTH; i++) r_entry[i] <= '0;
            r_older <= '0;
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < IQ_DEPTH; i++) r_entry[i].valid <= 1'b0;
            r_older <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) r_entry[i] <= w_entry_next[i];
            r_older <= w_older_next;
            r_count <= w_count_next;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && !flush) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (alloc_v[k]) begin
                    assert (!w_valid[alloc_addr[k*IQ_IDX_W +: IQ_IDX_W]]);
                    assert (w_eff[k]);
                end
            end
            assert (({1'b0, r_count} + 6'($countones(w_alloc_mask))) >= 6'($countones(w_grant_mask)));
            assert (({1'b0, r_count} + 6'($countones(w_alloc_mask)) - 6'($countones(w_grant_mask))) <= 6'd16);
        end
    end
`endif
endmodule

// File: tb/tb_iq_scheduler.sv
// Directed self-checking bench for iq_scheduler; expectations are hand-derived per scenario.
module tb_iq_scheduler;
    localparam int PW = 6;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           rst, flush;
    logic [3:0]     alloc_v, alloc_prs1_v, alloc_prs2_v, alloc_prd_v, alloc_prs1_rdy, alloc_prs2_rdy;
    logic [15:0]    alloc_addr;
    logic [23:0]    alloc_prs1, alloc_prs2, alloc_prd;
    logic [1:0]     wb_v, fu_rdy;
    logic [11:0]    wb_tag;
    logic [1:0]     issue_v, issue_prd_v;
    logic [7:0]     issue_idx;
    logic [11:0]    issue_prd;
    logic [15:0]    free_mask;
    logic [4:0]     iq_count;

    int checks = 0;
    int errors = 0;

    iq_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_v(alloc_v), .alloc_addr(alloc_addr),
        .alloc_prs1(alloc_prs1), .alloc_prs2(alloc_prs2), .alloc_prd(alloc_prd),
        .alloc_prs1_v(alloc_prs1_v), .alloc_prs2_v(alloc_prs2_v), .alloc_prd_v(alloc_prd_v),
        .alloc_prs1_rdy(alloc_prs1_rdy), .alloc_prs2_rdy(alloc_prs2_rdy),
        .wb_v(wb_v), .wb_tag(wb_tag), .fu_rdy(fu_rdy),
        .issue_v(issue_v), .issue_idx(issue_idx), .issue_prd(issue_prd),
        .issue_prd_v(issue_prd_v), .free_mask(free_mask), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; alloc_v = 0; alloc_addr = 0; alloc_prs1 = 0; alloc_prs2 = 0; alloc_prd = 0;
        alloc_prs1_v = 0; alloc_prs2_v = 0; alloc_prd_v = 0; alloc_prs1_rdy = 0; alloc_prs2_rdy = 0;
        wb_v = 0; wb_tag = 0;
    endtask

    task automatic set_slot(input int k, input logic [3:0] addr,
                            input logic [5:0] s1, input logic s1v, input logic s1r,
                            input logic [5:0] s2, input logic s2v, input logic s2r,
                            input logic [5:0] d, input logic dv);
        alloc_v[k] = 1'b1;
        alloc_addr[k*4 +: 4]   = addr;
        alloc_prs1[k*PW +: PW] = s1; alloc_prs1_v[k] = s1v; alloc_prs1_rdy[k] = s1r;
        alloc_prs2[k*PW +: PW] = s2; alloc_prs2_v[k] = s2v; alloc_prs2_rdy[k] = s2r;
        alloc_prd[k*PW +: PW]  = d;  alloc_prd_v[k]  = dv;
    endtask

    task automatic test_reset();
        rst = 1; fu_rdy = 2'b11; clear_inputs();
        tick(); tick();
        checks += 3;
        if (iq_count !== 5'd0)       begin errors++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
        if (free_mask !== 16'hFFFF)  begin errors++; $display("FAIL reset_free: got %h expected ffff", free_mask); end
        if (issue_v !== 2'b00)       begin errors++; $display("FAIL reset_issue_v: got %b expected 00", issue_v); end
        rst = 0;
        tick();
        $display("test_reset done: count=%0d free=%h", iq_count, free_mask);
    endtask

    task automatic test_basic();
        fu_rdy = 2'b11; clear_inputs();
        set_slot(0, 4'd5, 6'd0, 0, 0, 6'd0, 0, 0, 6'd10, 1);
        set_slot(1, 4'd2, 6'd0, 0, 0, 6'd0, 0, 0, 6'd11, 0);
        set_slot(2, 4'd9, 6'd0, 0, 0, 6'd0, 0, 0, 6'd12, 1);
        set_slot(3, 4'd0, 6'd0, 0, 0, 6'd0, 0, 0, 6'd13, 1);
        tick(); clear_inputs();
        checks += 6;
        if (iq_count !== 5'd4)        begin errors++; $display("FAIL basic_count1: got %0d expected 4", iq_count); end
        if (issue_v !== 2'b11)        begin errors++; $display("FAIL basic_v1: got %b expected 11", issue_v); end
        if (issue_idx !== 8'h25)      begin errors++; $display("FAIL basic_idx1: got %h expected 25", issue_idx); end
        if (issue_prd[5:0] !== 6'd10) begin errors++; $display("FAIL basic_prd1: got %0d expected 10", issue_prd[5:0]); end
        if (issue_prd_v !== 2'b01)    begin errors++; $display("FAIL basic_prdv1: got %b expected 01", issue_prd_v); end
        if (free_mask !== 16'hFDDA)   begin errors++; $display("FAIL basic_free1: got %h expected fdda", free_mask); end
        $display("test_basic cycle1: idx=%h count=%0d", issue_idx, iq_count);
        tick();
        checks += 5;
        if (iq_count !== 5'd2)        begin errors++; $display("FAIL basic_count2: got %0d expected 2", iq_count); end
        if (issue_idx !== 8'h09)      begin errors++; $display("FAIL basic_idx2: got %h expected 09", issue_idx); end
        if (issue_prd !== {6'd13, 6'd12}) begin errors++; $display("FAIL basic_prd2: got %h expected %h", issue_prd, {6'd13, 6'd12}); end
        if (issue_prd_v !== 2'b11)    begin errors++; $display("FAIL basic_prdv2: got %b expected 11", issue_prd_v); end
        if (free_mask !== 16'hFDFE)   begin errors++; $display("FAIL basic_free2: got %h expected fdfe", free_mask); end
        $display("test_basic cycle2: idx=%h count=%0d", issue_idx, iq_count);
        tick();
        checks += 3;
        if (iq_count !== 5'd0)        begin errors++; $display("FAIL basic_count3: got %0d expected 0", iq_count); end
        if (issue_v !== 2'b00)        begin errors++; $display("FAIL basic_v3: got %b expected 00", issue_v); end
        if (free_mask !== 16'hFFFF)   begin errors++; $display("FAIL basic_free3: got %h expected ffff", free_mask); end
        $display("test_basic cycle3: count=%0d", iq_count);
    endtask

    task automatic test_wakeup();
        fu_rdy = 2'b11; clear_inputs();
        set_slot(0, 4'd3, 6'd12, 1, 0, 6'd0, 0, 0, 6'd30, 1);
        tick(); clear_inputs();
        checks += 2;
        if (issue_v !== 2'b00) begin errors++; $display("FAIL wake_c1_v: got %b expected 00", issue_v); end
        if (iq_count !== 5'd1) begin errors++; $display("FAIL wake_c1_count: got %0d expected 1", iq_count); end
        tick();
        checks += 1;
        if (issue_v !== 2'b00) begin errors++; $display("FAIL wake_c2_v: got %b expected 00", issue_v); end
        wb_v = 2'b01; wb_tag = {6'd0, 6'd12};
        tick(); clear_inputs();
        checks += 2;
        if (issue_v !== 2'b01)        begin errors++; $display("FAIL wake_c3_v: got %b expected 01", issue_v); end
        if (issue_idx[3:0] !== 4'd3)  begin errors++; $display("FAIL wake_c3_idx: got %0d expected 3", issue_idx[3:0]); end
        tick();
        checks += 1;
        if (iq_count !== 5'd0) begin errors++; $display("FAIL wake_drain: got %0d expected 0", iq_count); end
        $display("test_wakeup done: count=%0d", iq_count);
    endtask

    task automatic test_alloc_wakeup();
        fu_rdy = 2'b11; clear_inputs();
        set_slot(2, 4'd7, 6'd0, 0, 0, 6'd7, 1, 0, 6'd31, 0);
        wb_v = 2'b10; wb_tag = {6'd7, 6'd0};
        tick(); clear_inputs();
        checks += 2;
        if (issue_v !== 2'b01)       begin errors++; $display("FAIL allocwake_v: got %b expected 01", issue_v); end
        if (issue_idx[3:0] !== 4'd7) begin errors++; $display("FAIL allocwake_idx: got %0d expected 7", issue_idx[3:0]); end
        tick();
        checks += 1;
        if (iq_count !== 5'd0) begin errors++; $display("FAIL allocwake_drain: got %0d expected 0", iq_count); end
        $display("test_alloc_wakeup done: count=%0d", iq_count);
    endtask

    task automatic test_single_port();
        fu_rdy = 2'b01; clear_inputs();
        set_slot(0, 4'd4, 6'd0, 0, 0, 6'd0, 0, 0, 6'd1, 1);
        set_slot(1, 4'd8, 6'd0, 0, 0, 6'd0, 0, 0, 6'd2, 1);
        set_slot(2, 4'd1, 6'd0, 0, 0, 6'd0, 0, 0, 6'd3, 1);
        tick(); clear_inputs();
        checks += 3;
        if (issue_idx !== 8'h84)    begin errors++; $display("FAIL sp_idx1: got %h expected 84", issue_idx); end
        if (free_mask !== 16'hFEED) begin errors++; $display("FAIL sp_free1: got %h expected feed", free_mask); end
        if (iq_count !== 5'd3)      begin errors++; $display("FAIL sp_count1: got %0d expected 3", iq_count); end
        tick();
        checks += 3;
        if (issue_idx !== 8'h18)    begin errors++; $display("FAIL sp_idx2: got %h expected 18", issue_idx); end
        if (free_mask !== 16'hFEFD) begin errors++; $display("FAIL sp_free2: got %h expected fefd", free_mask); end
        if (iq_count !== 5'd2)      begin errors++; $display("FAIL sp_count2: got %0d expected 2", iq_count); end
        tick();
        checks += 3;
        if (issue_v !== 2'b01 || issue_idx[3:0] !== 4'd1) begin errors++; $display("FAIL sp_sel3: got v=%b idx=%h expected v=01 idx=1", issue_v, issue_idx); end
        if (free_mask !== 16'hFFFD) begin errors++; $display("FAIL sp_free3: got %h expected fffd", free_mask); end
        if (iq_count !== 5'd1)      begin errors++; $display("FAIL sp_count3: got %0d expected 1", iq_count); end
        tick();
        checks += 1;
        if (free_mask !== 16'hFFFF) begin errors++; $display("FAIL sp_free4: got %h expected ffff", free_mask); end
        $display("test_single_port done: count=%0d free=%h", iq_count, free_mask);
    endtask

    task automatic test_age_order();
        fu_rdy = 2'b00; clear_inputs();
        set_slot(3, 4'd12, 6'd0, 0, 0, 6'd0, 0, 0, 6'd5, 1);
        tick(); clear_inputs();
        set_slot(0, 4'd1, 6'd0, 0, 0, 6'd0, 0, 0, 6'd6, 1);
        tick(); clear_inputs();
        checks += 2;
        if (issue_idx !== 8'h1C) begin errors++; $display("FAIL age_idx1: got %h expected 1c", issue_idx); end
        if (iq_count !== 5'd2)   begin errors++; $display("FAIL age_count1: got %0d expected 2", iq_count); end
        fu_rdy = 2'b10;
        tick();
        checks += 2;
        if (issue_v !== 2'b01 || issue_idx[3:0] !== 4'd12) begin errors++; $display("FAIL age_sel2: got v=%b idx=%h expected v=01 idx=c", issue_v, issue_idx); end
        if (iq_count !== 5'd1) begin errors++; $display("FAIL age_count2: got %0d expected 1", iq_count); end
        fu_rdy = 2'b01;
        tick();
        checks += 1;
        if (iq_count !== 5'd0) begin errors++; $display("FAIL age_count3: got %0d expected 0", iq_count); end
        $display("test_age_order done: count=%0d", iq_count);
    endtask

    task automatic test_fill_flush();
        fu_rdy = 2'b00;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            for (int k = 0; k < DW; k++) set_slot(k, 4'(c*4+k), 6'd0, 0, 0, 6'd0, 0, 0, 6'(c*4+k), 1);
            tick();
        end
        clear_inputs();
        checks += 4;
        if (iq_count !== 5'd16)   begin errors++; $display("FAIL fill_count: got %0d expected 16", iq_count); end
        if (free_mask !== 16'h0)  begin errors++; $display("FAIL fill_free: got %h expected 0000", free_mask); end
        if (issue_v !== 2'b11)    begin errors++; $display("FAIL fill_v: got %b expected 11", issue_v); end
        if (issue_idx !== 8'h10)  begin errors++; $display("FAIL fill_idx: got %h expected 10", issue_idx); end
        flush = 1; fu_rdy = 2'b11;
        tick(); clear_inputs();
        checks += 3;
        if (iq_count !== 5'd0)      begin errors++; $display("FAIL flush_count: got %0d expected 0", iq_count); end
        if (free_mask !== 16'hFFFF) begin errors++; $display("FAIL flush_free: got %h expected ffff", free_mask); end
        if (issue_v !== 2'b00)      begin errors++; $display("FAIL flush_v: got %b expected 00", issue_v); end
        flush = 1;
        set_slot(0, 4'd6, 6'd0, 0, 0, 6'd0, 0, 0, 6'd9, 1);
        tick(); clear_inputs();
        checks += 2;
        if (iq_count !== 5'd0)      begin errors++; $display("FAIL flush_alloc_count: got %0d expected 0", iq_count); end
        if (free_mask !== 16'hFFFF) begin errors++; $display("FAIL flush_alloc_free: got %h expected ffff", free_mask); end
        $display("test_fill_flush done: count=%0d free=%h", iq_count, free_mask);
    endtask

    task automatic test_back_to_back();
        fu_rdy = 2'b11; clear_inputs();
        set_slot(0, 4'd2, 6'd0, 0, 0, 6'd0, 0, 0, 6'd20, 1);
        set_slot(1, 4'd6, 6'd20, 1, 0, 6'd0, 0, 0, 6'd21, 1);
        tick(); clear_inputs();
        checks += 2;
        if (issue_v !== 2'b01)       begin errors++; $display("FAIL b2b_prod_v: got %b expected 01", issue_v); end
        if (issue_idx[3:0] !== 4'd2) begin errors++; $display("FAIL b2b_prod_idx: got %0d expected 2", issue_idx[3:0]); end
        tick();
`ifdef IQ_SPEC_WAKEUP_EN
        checks += 2;
        if (issue_v !== 2'b01)       begin errors++; $display("FAIL b2b_cons_v: got %b expected 01", issue_v); end
        if (issue_idx[3:0] !== 4'd6) begin errors++; $display("FAIL b2b_cons_idx: got %0d expected 6", issue_idx[3:0]); end
`else
        checks += 1;
        if (issue_v !== 2'b00) begin errors++; $display("FAIL b2b_wait_v: got %b expected 00", issue_v); end
        wb_v = 2'b01; wb_tag = {6'd0, 6'd20};
        tick(); clear_inputs();
        checks += 2;
        if (issue_v !== 2'b01)       begin errors++; $display("FAIL b2b_cons_v: got %b expected 01", issue_v); end
        if (issue_idx[3:0] !== 4'd6) begin errors++; $display("FAIL b2b_cons_idx: got %0d expected 6", issue_idx[3:0]); end
`endif
        tick();
        checks += 1;
        if (iq_count !== 5'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", iq_count); end
        $display("test_back_to_back done: count=%0d", iq_count);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_alloc_wakeup();
        test_single_port();
        test_age_order();
        test_fill_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
